seg_scan_counter: RTL and testbench

Parametrised multi-digit display counter driving a time-multiplexed seven-segment display from the dedicated outputs. A prescaler divides `clk` into count ticks. An N-digit counter steps up or down on each tick, in hex or BCD, with wrap detection. A scan engine cycles one-hot digit enables and presents the selected digit's glyph, with optional leading-zero blanking and a heartbeat decimal point.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_glyph.sv | 38 +++
 rtl/seg_scan_counter.sv | 182 ++++++++++++++++++
 tb/tb_seg_scan_counter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan counter: glyph encodings and digit limits.
// Latency: none (constants only).
// Backpressure: none; the display path is free-running.
//
// Segment bit order is a..g on bits 0..6; a set bit lights the segment.
package seg_pkg;

    // Supported digit counts for seg_scan_counter.
    localparam int MIN_DIGITS = 2;
    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] GLYPH_0   = 7'h3F;
    localparam logic [6:0] GLYPH_1   = 7'h06;
    localparam logic [6:0] GLYPH_2   = 7'h5B;
    localparam logic [6:0] GLYPH_3   = 7'h4F;
    localparam logic [6:0] GLYPH_4   = 7'h66;
    localparam logic [6:0] GLYPH_5   = 7'h6D;
    localparam logic [6:0] GLYPH_6   = 7'h7D;
    localparam logic [6:0] GLYPH_7   = 7'h07;
    localparam logic [6:0] GLYPH_8   = 7'h7F;
    localparam logic [6:0] GLYPH_9   = 7'h6F;
    localparam logic [6:0] GLYPH_A   = 7'h77;
    localparam logic [6:0] GLYPH_B   = 7'h7C;
    localparam logic [6:0] GLYPH_C   = 7'h39;
    localparam logic [6:0] GLYPH_D   = 7'h5E;
    localparam logic [6:0] GLYPH_E   = 7'h79;
    localparam logic [6:0] GLYPH_F   = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_glyph.sv
// Nibble to seven-segment glyph lookup (hex glyphs 0..F).
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   nib  - 4-bit digit value to display
//   seg  - segments a..g on bits 0..6, active-high
module seg_glyph
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_counter.sv
// Prescaled up/down hex/BCD multi-digit counter with a time-multiplexed seven-segment scan.
// Latency: outputs are registered and reflect counter/scan state one cycle later; wrap pulses with the new value.
// Backpressure: none; the scan runs freely and run=0 only freezes the count.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   run, up, mode_bcd     - prescaler enable, count direction, per-digit radix (BCD vs hex)
//   lz_blank, clear       - leading-zero blanking, synchronous clear of value and prescaler
//   seg_out, dp_out       - glyph and heartbeat decimal point of the scanned digit
//   digit_en, wrap        - one-hot digit select, one-cycle wrap pulse
//   DIGITS is expected to lie within seg_pkg::MIN_DIGITS..MAX_DIGITS.
module seg_scan_counter
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 21,
    parameter int SCAN_W     = 10,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              up,
    input  logic              mode_bcd,
    input  logic              lz_blank,
    input  logic              clear,
    output logic [6:0]        seg_out,
    output logic              dp_out,
    output logic [DIGITS-1:0] digit_en,
    output logic              wrap
);

    localparam int VW    = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Output polarity masks; XOR at the output registers so reset values flip too.
    localparam logic [6:0]        SEG_INV = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_INV  = (ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] EN_INV  = {DIGITS{ACTIVE_LOW != 0}};

    logic [PRESCALE_W-1:0] presc;
    logic [VW-1:0]         value;
    logic [VW-1:0]         value_nxt;
    logic                  carry_out;
    logic                  tick;

    logic [SCAN_W-1:0]     scan_div;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            cur_nib;
    logic [6:0]            glyph;
    logic [DIGITS-1:0]     blank_mask;
    logic                  blank;

    assign tick = run & (&presc);

    // ------------------------------------------------------------------
    // Per-digit step with carry/borrow rippling from digit 0 upward.
    // Digit 0 always receives a carry-in; the result is only committed on a tick.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] cur;
            logic [3:0] nxt;
            logic       cin;
            logic       cout;

            if (i == 0) begin : g_lsd
                assign cin = 1'b1;
            end else begin : g_upper
                assign cin = g_digit[i-1].cout;
            end

            assign cur = value[4*i +: 4];

            always_comb begin
                nxt  = cur;
                cout = 1'b0;
                if (cin) begin
                    if (up) begin
                        // In BCD anything >= 9 rolls over, which also flushes
                        // A..F left behind by a switch from hex mode.
                        if (mode_bcd ? (cur >= 4'd9) : (cur == 4'hF)) begin
                            nxt  = 4'h0;
                            cout = 1'b1;
                        end else begin
                            nxt = cur + 4'd1;
                        end
                    end else begin
                        if (cur == 4'h0) begin
                            nxt  = mode_bcd ? 4'd9 : 4'hF;
                            cout = 1'b1;
                        end else if (mode_bcd && (cur > 4'd9)) begin
                            // Illegal BCD digit snaps to 9 without borrowing.
                            nxt = 4'd9;
                        end else begin
                            nxt = cur - 4'd1;
                        end
                    end
                end
            end

            assign value_nxt[4*i +: 4] = nxt;
        end
    endgenerate

    assign carry_out = g_digit[DIGITS-1].cout;

    // ------------------------------------------------------------------
    // Prescaler, counter value and wrap pulse. clear beats a coincident tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            value <= '0;
            wrap  <= 1'b0;
        end else if (clear) begin
            presc <= '0;
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            if (run) begin
                presc <= presc + PRESCALE_W'(1);
            end
            if (tick) begin
                value <= value_nxt;
                wrap  <= carry_out;
            end else begin
                wrap  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan engine: free-running divider, independent of run and clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_div <= '0;
            idx      <= '0;
        end else begin
            scan_div <= scan_div + SCAN_W'(1);
            if (&scan_div) begin
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Digit i (i >= 1) is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic hi_zero;
        hi_zero    = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero       = hi_zero & (value[4*i +: 4] == 4'h0);
            blank_mask[i] = hi_zero;
        end
    end

    assign cur_nib = 4'(value >> {idx, 2'b00});
    assign blank   = lz_blank & blank_mask[idx];

    seg_glyph u_glyph (
        .nib (cur_nib),
        .seg (glyph)
    );

    // ------------------------------------------------------------------
    // Output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out  <= SEG_INV;
            dp_out   <= DP_INV;
            digit_en <= EN_INV;
        end else begin
            seg_out  <= (blank ? SEG_BLANK : glyph) ^ SEG_INV;
            dp_out   <= ((idx == '0) & presc[PRESCALE_W-1]) ^ DP_INV;
            digit_en <= (DIGITS'(1) << idx) ^ EN_INV;
        end
    end

endmodule

// File: tb/tb_seg_scan_counter.sv
// Self-checking bench for seg_scan_counter (DIGITS=4, PRESCALE_W=2, SCAN_W=1).
// A tick happens every 4 run cycles; the bench always runs in multiples of 4 so the
// prescaler returns to 0. Expected glyphs are queued per digit and popped when scanned.
module tb_seg_scan_counter;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       run      = 1'b0;
    logic       up       = 1'b1;
    logic       mode_bcd = 1'b0;
    logic       lz_blank = 1'b0;
    logic       clear    = 1'b0;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [3:0] digit_en;
    logic       wrap;

    int n_tests = 0;
    int n_fail  = 0;

    int   wrap_cnt  = 0;
    int   wrap_long = 0;
    logic wrap_prev = 1'b0;

    typedef struct {
        int         dig;
        logic [6:0] glyph;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    seg_scan_counter #(
        .DIGITS     (4),
        .PRESCALE_W (2),
        .SCAN_W     (1),
        .ACTIVE_LOW (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .up       (up),
        .mode_bcd (mode_bcd),
        .lz_blank (lz_blank),
        .clear    (clear),
        .seg_out  (seg_out),
        .dp_out   (dp_out),
        .digit_en (digit_en),
        .wrap     (wrap)
    );

    // Count wrap pulses and any pulse lasting longer than one cycle.
    always @(negedge clk) begin
        if (wrap === 1'b1) begin
            wrap_cnt++;
            if (wrap_prev === 1'b1) wrap_long++;
        end
        wrap_prev = wrap;
    end

    task automatic ticks(input int n);
        @(posedge clk);
        #1 run = 1'b1;
        repeat (4 * n) @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    task automatic wait_digit(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (digit_en === (4'b0001 << k)) ok = 1'b1;
        end
    endtask

    // Queue the expected glyph per digit, then pop each as the scan presents it.
    task automatic check_digits(input string name, input logic [6:0] g0, input logic [6:0] g1,
                                input logic [6:0] g2, input logic [6:0] g3);
        exp_t e;
        int   budget;
        repeat (3) @(negedge clk);
        e.dig = 0; e.glyph = g0; sb.push_back(e);
        e.dig = 1; e.glyph = g1; sb.push_back(e);
        e.dig = 2; e.glyph = g2; sb.push_back(e);
        e.dig = 3; e.glyph = g3; sb.push_back(e);
        budget = 40;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (digit_en === (4'b0001 << sb[0].dig)) begin
                e = sb.pop_front();
                n_tests++;
                if (seg_out !== e.glyph) begin
                    n_fail++;
                    $display("FAIL %s digit%0d: seg_out=%h expected %h", name, e.dig, seg_out, e.glyph);
                end
            end
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scan timeout: %0d digits not seen, digit_en=%b", name, sb.size(), digit_en);
            sb.delete();
        end
    endtask

    // After a single tick: wrap high for exactly the next cycle when expected.
    task automatic check_wrap_pulse(input string name, input logic exp_wrap);
        @(negedge clk);
        n_tests++;
        if (wrap !== exp_wrap) begin
            n_fail++;
            $display("FAIL %s wrap: got %b expected %b", name, wrap, exp_wrap);
        end
        @(negedge clk);
        n_tests++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wrap width: got %b expected 0 one cycle later", name, wrap);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({seg_out, dp_out, digit_en, wrap} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_hold: seg=%h dp=%b en=%b wrap=%b expected all 0", seg_out, dp_out, digit_en, wrap);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (digit_en !== 4'b0001 || seg_out !== 7'h3F) begin
            n_fail++;
            $display("FAIL reset_first: en=%b seg=%h expected 0001/3f", digit_en, seg_out);
        end
        // Count to 5, then reset asynchronously mid-count.
        ticks(5);
        check_digits("count5", 7'h6D, 7'h3F, 7'h3F, 7'h3F);
        @(posedge clk);
        #1 run = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({seg_out, dp_out, digit_en, wrap} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_mid: seg=%h dp=%b en=%b wrap=%b expected all 0", seg_out, dp_out, digit_en, wrap);
        end
        run = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (digit_en !== 4'b0001 || seg_out !== 7'h3F) begin
            n_fail++;
            $display("FAIL reset_mid_first: en=%b seg=%h expected 0001/3f", digit_en, seg_out);
        end
        check_digits("after_reset", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    endtask

    task automatic test_heartbeat();
        bit ok;
        do_clear();
        @(posedge clk);
        #1 run = 1'b1;
        repeat (2) @(posedge clk);  // prescaler = 2, MSB set
        #1 run = 1'b0;
        wait_digit(0, ok);
        n_tests++;
        if (!ok || dp_out !== 1'b1) begin
            n_fail++;
            $display("FAIL dp_digit0: ok=%b dp=%b expected 1", ok, dp_out);
        end
        wait_digit(1, ok);
        n_tests++;
        if (!ok || dp_out !== 1'b0) begin
            n_fail++;
            $display("FAIL dp_digit1: ok=%b dp=%b expected 0", ok, dp_out);
        end
        do_clear();  // prescaler back to 0
        wait_digit(0, ok);
        n_tests++;
        if (!ok || dp_out !== 1'b0) begin
            n_fail++;
            $display("FAIL dp_after_clear: ok=%b dp=%b expected 0", ok, dp_out);
        end
    endtask

    task automatic test_bcd_up();
        int w0;
        do_clear();
        mode_bcd = 1'b1; up = 1'b1; lz_blank = 1'b0;
        w0 = wrap_cnt;
        ticks(99);
        check_digits("bcd_0099", 7'h6F, 7'h6F, 7'h3F, 7'h3F);
        ticks(1);
        check_digits("bcd_0100", 7'h3F, 7'h3F, 7'h06, 7'h3F);
        n_tests++;
        if (wrap_cnt !== w0) begin
            n_fail++;
            $display("FAIL bcd_up_nowrap: wraps=%0d expected 0", wrap_cnt - w0);
        end
    endtask

    task automatic test_bcd_wrap();
        do_clear();
        mode_bcd = 1'b1; up = 1'b0;
        ticks(1);
        check_wrap_pulse("bcd_down_0000", 1'b1);
        check_digits("bcd_9999", 7'h6F, 7'h6F, 7'h6F, 7'h6F);
        up = 1'b1;
        ticks(1);
        check_wrap_pulse("bcd_up_9999", 1'b1);
        check_digits("bcd_wrap_0000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    endtask

    task automatic test_hex_down();
        do_clear();
        mode_bcd = 1'b0; up = 1'b0;
        ticks(1);
        check_wrap_pulse("hex_down_0000", 1'b1);
        check_digits("hex_ffff", 7'h71, 7'h71, 7'h71, 7'h71);
        // Illegal BCD digits left over from hex mode.
        mode_bcd = 1'b1;
        ticks(1);
        check_wrap_pulse("bcd_down_ffff", 1'b0);
        check_digits("bcd_fff9", 7'h6F, 7'h71, 7'h71, 7'h71);
        up = 1'b1;
        ticks(1);
        check_wrap_pulse("bcd_up_fff9", 1'b1);
        check_digits("bcd_flush_0000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    endtask

    task automatic test_lz_blank();
        do_clear();
        mode_bcd = 1'b0; up = 1'b1;
        ticks(66);  // 0x0042
        lz_blank = 1'b1;
        check_digits("lz_on_0042", 7'h5B, 7'h66, 7'h00, 7'h00);
        lz_blank = 1'b0;
        check_digits("lz_off_0042", 7'h5B, 7'h66, 7'h3F, 7'h3F);
        lz_blank = 1'b1;
        do_clear();
        check_digits("lz_on_0000", 7'h3F, 7'h00, 7'h00, 7'h00);
        lz_blank = 1'b0;
    endtask

    task automatic test_clear_tick();
        int         w0;
        logic [3:0] seen;
        int         bad_onehot;
        do_clear();
        mode_bcd = 1'b0; up = 1'b1;
        ticks(291);  // 0x0123
        check_digits("hex_0123", 7'h4F, 7'h5B, 7'h06, 7'h3F);
        w0 = wrap_cnt;
        @(posedge clk);
        #1 run = 1'b1;
        repeat (3) @(posedge clk);  // prescaler = 3: next edge would tick
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        run = 1'b0;
        check_digits("clear_tick", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        n_tests++;
        if (wrap_cnt !== w0) begin
            n_fail++;
            $display("FAIL clear_tick_wrap: wraps=%0d expected 0", wrap_cnt - w0);
        end
        // Frozen count, scan keeps rotating.
        seen = 4'b0000;
        bad_onehot = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | digit_en;
            if (!$onehot(digit_en)) bad_onehot++;
        end
        n_tests++;
        if (seen !== 4'b1111 || bad_onehot !== 0) begin
            n_fail++;
            $display("FAIL freeze_scan: seen=%b non_onehot=%0d expected 1111/0", seen, bad_onehot);
        end
        check_digits("freeze_value", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        ticks(1);
        check_digits("after_clear_tick", 7'h06, 7'h3F, 7'h3F, 7'h3F);
        n_tests++;
        if (wrap_long !== 0) begin
            n_fail++;
            $display("FAIL wrap_width: long pulses=%0d expected 0", wrap_long);
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_bcd_up();
        test_bcd_wrap();
        test_hex_down();
        test_lz_blank();
        test_clear_tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
